// File: rtl/mini_alu_pkg.sv
// Shared definitions for the control-unit fetch path: instruction geometry,
// HALT encoding and sequencer states.
package mini_alu_pkg;

  localparam int INSTR_W    = 48;
  localparam int OPCODE_MSB = 47;
  localparam int OPCODE_LSB = 39;
  localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  localparam logic [OPCODE_W-1:0] HALT_OPCODE = 9'h1FF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  function automatic logic is_halt(input logic [OPCODE_W-1:0] opc);
    return opc == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/program_store.sv
// Program memory: register array with one synchronous write port and one
// asynchronous read port. Contents are not reset.
module program_store
  import mini_alu_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               CLK,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic [AW-1:0]      rd_addr,
  output logic [INSTR_W-1:0] rd_data
);

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_sequencer.sv
// Fetch sequencer: loads a program through a valid/ready port, then issues
// it one instruction per clock until end of program or a HALT opcode.
module instr_sequencer
  import mini_alu_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH) + 1
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               LOAD_VALID,
  input  logic [INSTR_W-1:0] LOAD_DATA,
  output logic               LOAD_READY,
  input  logic               START,
  input  logic               STALL,
  input  logic               CLEAR,
  output logic [INSTR_W-1:0] INSTRUCTION,
  output logic               ISSUE_VALID,
  output logic               BUSY,
  output logic               DONE,
  output logic [PW-1:0]      PC,
  output logic [PW-1:0]      COUNT
);

  localparam int AW = PW - 1;
  localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);

  seq_state_e         state_q;
  seq_state_e         state_nxt;
  logic [PW-1:0]      pc_q;
  logic [PW-1:0]      count_q;
  logic [PW-1:0]      count_ld;
  logic               load_fire;
  logic [INSTR_W-1:0] fetch_word;
  logic               at_end;
  logic               fetch_halt;

  logic               busy_c;
  logic               done_c;
  logic               issue_en;
  logic               pc_rst;
  logic               cnt_clr;

  logic [INSTR_W-1:0] instr_p0;
  logic               vld_p0;

  assign LOAD_READY = (state_q == ST_IDLE) && (count_q < FULL_CNT);
  assign load_fire  = LOAD_VALID && LOAD_READY;
  // Count including a same-cycle load, so START can launch a program whose
  // only word is arriving right now.
  assign count_ld   = count_q + PW'(load_fire);

  program_store #(.DEPTH(DEPTH)) u_store (
    .CLK     (CLK),
    .wr_en   (load_fire),
    .wr_addr (count_q[AW-1:0]),
    .wr_data (LOAD_DATA),
    .rd_addr (pc_q[AW-1:0]),
    .rd_data (fetch_word)
  );

  assign at_end     = (pc_q == count_q);
  assign fetch_halt = is_halt(fetch_word[OPCODE_MSB:OPCODE_LSB]);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      ST_IDLE: if (START && (count_ld != '0)) state_nxt = ST_RUN;
      ST_RUN:  if (!STALL && (at_end || fetch_halt)) state_nxt = ST_DONE;
      ST_DONE: begin
        if (START)      state_nxt = ST_RUN;
        else if (CLEAR) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_c   = 1'b0;
    done_c   = 1'b0;
    issue_en = 1'b0;
    pc_rst   = 1'b0;
    cnt_clr  = 1'b0;
    unique case (state_q)
      ST_IDLE: pc_rst = START && (count_ld != '0);
      ST_RUN: begin
        busy_c   = 1'b1;
        issue_en = !STALL && !at_end && !fetch_halt;
      end
      ST_DONE: begin
        done_c  = 1'b1;
        pc_rst  = START || CLEAR;
        cnt_clr = !START && CLEAR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count_q <= '0;
      pc_q    <= '0;
    end else begin
      if (cnt_clr)        count_q <= '0;
      else if (load_fire) count_q <= count_ld;
      if (pc_rst)         pc_q <= '0;
      else if (issue_en)  pc_q <= pc_q + PW'(1);
    end
  end

  // Issue stage: registers the asynchronous store read onto INSTRUCTION.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      instr_p0 <= '0;
      vld_p0   <= 1'b0;
    end else begin
      vld_p0 <= issue_en;
      if (issue_en) instr_p0 <= fetch_word;
    end
  end

  assign INSTRUCTION = instr_p0;
  assign ISSUE_VALID = vld_p0;
  assign BUSY        = busy_c;
  assign DONE        = done_c;
  assign PC          = pc_q;
  assign COUNT       = count_q;

endmodule
